// File: rtl/mutex_client_ctrl.sv
// Two-client requester for a cross-coupled-NAND mutex: turns "acquire for N cycles"
// commands into four-phase req/grant handshakes and reports ownership and faults.

module mutex_client_fsm #(
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             grant,
    output logic             req,
    output logic             own,
    output logic             busy,
    output logic             done,
    output logic             tmo,
    output logic             grant_s
);

    typedef enum logic [1:0] {IDLE, REQ, OWN, REL} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [LEN_W-1:0]       hold_q, hold_d;
    logic [15:0]            wait_q, wait_d;
    logic [16:0]            wait_inc;
    logic                   owned_q, owned_d;
    logic                   done_d, tmo_d;

    // The mutex grant is asynchronous to clk; only the synchronised copy is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], grant};
        end
    end

    assign grant_s  = sync_q[SYNC_STAGES-1];
    assign wait_inc = {1'b0, wait_q} + 17'd1;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wait_d  = wait_q;
        owned_d = owned_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    hold_d  = (len == '0) ? LEN_W'(1) : len;
                    wait_d  = '0;
                    owned_d = 1'b0;
                end
            end
            REQ: begin
                if (grant_s) begin
                    state_d = OWN;
                    owned_d = 1'b1;
                end else begin
                    if (wait_q != 16'hFFFF) begin
                        wait_d = wait_inc[15:0];
                    end
                    if (wait_inc >= 17'(TIMEOUT)) begin
                        state_d = REL;
                        tmo_d   = 1'b1;
                    end
                end
            end
            OWN: begin
                if (hold_q <= LEN_W'(1)) begin
                    state_d = REL;
                end else begin
                    hold_d = hold_q - LEN_W'(1);
                end
            end
            REL: begin
                // A timed-out request may still be granted late; wait for that grant to drain.
                if (!grant_s) begin
                    state_d = IDLE;
                    done_d  = owned_q;
                    owned_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            wait_q  <= '0;
            owned_q <= 1'b0;
            req     <= 1'b0;
            own     <= 1'b0;
            done    <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            wait_q  <= wait_d;
            owned_q <= owned_d;
            req     <= (state_d == REQ) || (state_d == OWN);
            own     <= (state_d == OWN);
            done    <= done_d;
            tmo     <= tmo_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

module mutex_client_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start0,
    input  logic [LEN_W-1:0] len0,
    input  logic             start1,
    input  logic [LEN_W-1:0] len1,
    output logic             req0,
    output logic             req1,
    input  logic             grant0,
    input  logic             grant1,
    output logic             own0,
    output logic             own1,
    output logic             busy0,
    output logic             busy1,
    output logic             done0,
    output logic             done1,
    output logic             tmo0,
    output logic             tmo1,
    output logic             err_overlap
);

    logic grant_s0, grant_s1;

    mutex_client_fsm #(
        .SYNC_STAGES(SYNC_STAGES),
        .LEN_W      (LEN_W),
        .TIMEOUT    (TIMEOUT)
    ) u_client0 (
        .clk    (clk),
        .reset  (reset),
        .start  (start0),
        .len    (len0),
        .grant  (grant0),
        .req    (req0),
        .own    (own0),
        .busy   (busy0),
        .done   (done0),
        .tmo    (tmo0),
        .grant_s(grant_s0)
    );

    mutex_client_fsm #(
        .SYNC_STAGES(SYNC_STAGES),
        .LEN_W      (LEN_W),
        .TIMEOUT    (TIMEOUT)
    ) u_client1 (
        .clk    (clk),
        .reset  (reset),
        .start  (start1),
        .len    (len1),
        .grant  (grant1),
        .req    (req1),
        .own    (own1),
        .busy   (busy1),
        .done   (done1),
        .tmo    (tmo1),
        .grant_s(grant_s1)
    );

    // Sticky: once the mutex has ever granted both sides, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overlap <= 1'b0;
        end else begin
            err_overlap <= err_overlap | (grant_s0 & grant_s1);
        end
    end

endmodule

// File: tb/tb_mutex_client_ctrl.sv
// Bench for mutex_client_ctrl: directed vector table, corner-case sequences and
// randomized single-client transactions checked against a timestamp model.

module tb_mutex_client_ctrl;

    localparam logic [10:0] R0 = 11'h400, R1 = 11'h200, O0 = 11'h100, O1 = 11'h080;
    localparam logic [10:0] B0 = 11'h040, B1 = 11'h020, D0 = 11'h010, D1 = 11'h008;
    localparam logic [10:0] T0 = 11'h004, T1 = 11'h002, ERR = 11'h001;

    typedef struct {
        logic        s0;
        logic [7:0]  l0;
        logic        s1;
        logic [7:0]  l1;
        logic [10:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] len0 = 8'd0, len1 = 8'd0;
    logic       req0, req1, grant0, grant1;
    logic       own0, own1, busy0, busy1, done0, done1, tmo0, tmo1, err_overlap;
    logic       g0 = 1'b0, g1 = 1'b0, inj = 1'b0;
    logic       n0, n1;
    logic [10:0] outv;

    int vectors = 0;
    int miscompares = 0;
    int t_own0, t_own1, t_rel0, t_rel1, nd0, nd1;
    int t_own_w, t_rel_w, t_own_l;

    vec_t tbl [21];

    mutex_client_ctrl #(
        .SYNC_STAGES(2),
        .LEN_W      (8),
        .TIMEOUT    (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start0     (start0),
        .len0       (len0),
        .start1     (start1),
        .len1       (len1),
        .req0       (req0),
        .req1       (req1),
        .grant0     (grant0),
        .grant1     (grant1),
        .own0       (own0),
        .own1       (own1),
        .busy0      (busy0),
        .busy1      (busy1),
        .done0      (done0),
        .done1      (done1),
        .tmo0       (tmo0),
        .tmo1       (tmo1),
        .err_overlap(err_overlap)
    );

    always #5 clk = ~clk;

    assign outv = {req0, req1, own0, own1, busy0, busy1, done0, done1, tmo0, tmo1, err_overlap};

    // Behavioural mutex: a grant is held while its request stays high; a free
    // mutex grants a lone requester, or a random one of two simultaneous requesters.
    assign grant0 = g0 | inj;
    assign grant1 = g1 | inj;

    always @(negedge clk) begin
        n0 = g0 & req0;
        n1 = g1 & req1;
        if (!n0 && !n1) begin
            if (req0 && req1) begin
                if ($urandom_range(0, 1) == 1) n0 = 1'b1;
                else n1 = 1'b1;
            end else if (req0) begin
                n0 = 1'b1;
            end else if (req1) begin
                n1 = 1'b1;
            end
        end
        g0 <= n0;
        g1 <= n1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_stimulus(input logic s0, input logic [7:0] l0,
                                  input logic s1, input logic [7:0] l1);
        start0 = s0;
        len0   = l0;
        start1 = s1;
        len1   = l1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic check_output(input string name, input logic [10:0] exp);
        vectors++;
        if (outv !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b expected %b (req0 req1 own0 own1 busy0 busy1 done0 done1 tmo0 tmo1 err)",
                     name, outv, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s0, input logic [7:0] l0, input logic [10:0] e);
        vec_t v;
        v.s0 = s0;
        v.l0 = l0;
        v.s1 = 1'b0;
        v.l1 = 8'd0;
        v.exp = e;
        return v;
    endfunction

    // Free-mutex timeline, k edges after the start-sampling edge, effective length L:
    // request through edge L+2, ownership from edge 3 to L+2, done on edge L+6.
    function automatic logic [10:0] exp_single(input int c, input int k, input int L);
        logic [10:0] v;
        v = '0;
        if (k <= L + 2) v |= R0;
        if (k >= 3 && k <= L + 2) v |= O0;
        if (k <= L + 5) v |= B0;
        if (k == L + 6) v |= D0;
        return (c == 0) ? v : (v >> 1);
    endfunction

    task automatic run_txn(input int c, input int len_in, input bit noise, input string name);
        int         L;
        logic       s;
        logic [7:0] l;
        L = (len_in == 0) ? 1 : len_in;
        if (c == 0) apply_stimulus(1'b1, 8'(len_in), 1'b0, 8'd0);
        else apply_stimulus(1'b0, 8'd0, 1'b1, 8'(len_in));
        check_output(name, exp_single(c, 0, L));
        for (int k = 1; k <= L + 6; k++) begin
            s = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            l = 8'($urandom_range(0, 255));
            if (c == 0) apply_stimulus(s, l, 1'b0, 8'd0);
            else apply_stimulus(1'b0, 8'd0, s, l);
            check_output(name, exp_single(c, k, L));
        end
    endtask

    initial begin
        // Single client len=4 with ignored restarts, then len=0 treated as 1.
        tbl[0]  = mk(1'b1, 8'd4, R0 | B0);
        tbl[1]  = mk(1'b0, 8'd0, R0 | B0);
        tbl[2]  = mk(1'b0, 8'd0, R0 | B0);
        tbl[3]  = mk(1'b0, 8'd0, R0 | O0 | B0);
        tbl[4]  = mk(1'b1, 8'd9, R0 | O0 | B0);
        tbl[5]  = mk(1'b0, 8'd0, R0 | O0 | B0);
        tbl[6]  = mk(1'b0, 8'd0, R0 | O0 | B0);
        tbl[7]  = mk(1'b0, 8'd0, B0);
        tbl[8]  = mk(1'b1, 8'd2, B0);
        tbl[9]  = mk(1'b0, 8'd0, B0);
        tbl[10] = mk(1'b0, 8'd0, D0);
        tbl[11] = mk(1'b0, 8'd0, 11'h000);
        tbl[12] = mk(1'b1, 8'd0, R0 | B0);
        tbl[13] = mk(1'b0, 8'd0, R0 | B0);
        tbl[14] = mk(1'b0, 8'd0, R0 | B0);
        tbl[15] = mk(1'b0, 8'd0, R0 | O0 | B0);
        tbl[16] = mk(1'b0, 8'd0, B0);
        tbl[17] = mk(1'b0, 8'd0, B0);
        tbl[18] = mk(1'b0, 8'd0, B0);
        tbl[19] = mk(1'b0, 8'd0, D0);
        tbl[20] = mk(1'b0, 8'd0, 11'h000);

        reset = 1'b1;
        idle();
        idle();
        check_output("reset_state", 11'h000);
        reset = 1'b0;
        idle();
        check_output("idle_after_reset", 11'h000);

        for (int i = 0; i < 21; i++) begin
            apply_stimulus(tbl[i].s0, tbl[i].l0, tbl[i].s1, tbl[i].l1);
            check_output($sformatf("table_row%0d", i), tbl[i].exp);
        end

        // Simultaneous starts: the mutex picks one, the other follows its release.
        t_own0 = -1; t_own1 = -1; t_rel0 = -1; t_rel1 = -1; nd0 = 0; nd1 = 0;
        apply_stimulus(1'b1, 8'd3, 1'b1, 8'd3);
        check_output("simul_start", R0 | B0 | R1 | B1);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            idle();
            check_int("simul_dual_own", int'(own0 & own1), 0);
            if (own0 && t_own0 < 0) t_own0 = cyc;
            if (own1 && t_own1 < 0) t_own1 = cyc;
            if (t_own0 >= 0 && !req0 && t_rel0 < 0) t_rel0 = cyc;
            if (t_own1 >= 0 && !req1 && t_rel1 < 0) t_rel1 = cyc;
            if (done0) nd0++;
            if (done1) nd1++;
        end
        if (t_own0 >= 0 && (t_own1 < 0 || t_own0 < t_own1)) begin
            t_own_w = t_own0; t_rel_w = t_rel0; t_own_l = t_own1;
        end else begin
            t_own_w = t_own1; t_rel_w = t_rel1; t_own_l = t_own0;
        end
        check_int("simul_winner_own_edge", t_own_w, 3);
        check_int("simul_winner_hold", t_rel_w - t_own_w, 3);
        check_int("simul_loser_latency", t_own_l - t_rel_w, 3);
        check_int("simul_done0_count", nd0, 1);
        check_int("simul_done1_count", nd1, 1);
        check_int("simul_err_overlap", int'(err_overlap), 0);

        // Timeout: client 1 holds for a long time, client 0 gives up after 10 cycles.
        apply_stimulus(1'b0, 8'd0, 1'b1, 8'd255);
        for (int i = 0; i < 8 && !own1; i++) idle();
        check_int("tmo_own1_acquired", int'(own1), 1);
        apply_stimulus(1'b1, 8'd0, 1'b0, 8'd0);
        check_output("tmo_k0", R0 | B0 | R1 | O1 | B1);
        for (int k = 1; k <= 12; k++) begin
            logic [10:0] e;
            e = R1 | O1 | B1;
            if (k < 10) e |= R0 | B0;
            else if (k == 10) e |= B0 | T0;
            idle();
            check_output($sformatf("tmo_k%0d", k), e);
        end

        // One-cycle reset while client 1 still owns the resource.
        reset = 1'b1;
        idle();
        check_output("reset_midop", 11'h000);
        reset = 1'b0;
        idle();
        check_output("after_reset_midop", 11'h000);
        run_txn(0, 5, 1'b0, "post_reset_txn");

        // Randomized single-client transactions with ignored start noise.
        for (int n = 0; n < 25; n++) begin
            int c;
            int len;
            int gap;
            c   = int'($urandom_range(0, 1));
            len = int'($urandom_range(0, 30));
            gap = int'($urandom_range(0, 3));
            run_txn(c, len, 1'b1, $sformatf("rand_txn%0d", n));
            for (int g = 0; g < gap; g++) begin
                idle();
                check_output("rand_gap", 11'h000);
            end
        end

        // Overlap injection: both grants forced high for three cycles.
        inj = 1'b1;
        idle();
        check_output("ovl_edge1", 11'h000);
        idle();
        idle();
        inj = 1'b0;
        check_output("ovl_edge3", ERR);
        for (int i = 0; i < 5; i++) begin
            idle();
            check_output("ovl_sticky", ERR);
        end
        reset = 1'b1;
        idle();
        check_output("ovl_reset", 11'h000);
        reset = 1'b0;
        idle();
        check_output("ovl_after_reset", 11'h000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
